// File: rtl/dma_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU load/store port and the DMA engine,
// with burst ownership, a starvation bound and owner-tagged read-data return.
module dma_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state,
    output logic [CNT_W-1:0]      dbg_burst_cnt
);
    // Handshake: a requester holds req and its fields until it sees gnt in the same cycle;
    // gnt is the acceptance, writes finish there, reads return one cycle later with rvalid.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DMA  = 2'd1;
    localparam logic [1:0] ST_CPU  = 2'd2;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_pend_q, rd_dma_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;
    logic                  cpu_act, dma_act, own_is_dma, own_req, oth_req;

    // Requests are masked while reset is asserted so nothing is granted during reset.
    assign cpu_act    = cpu_req & rst_n;
    assign dma_act    = dma_req & rst_n;
    assign own_is_dma = (state_q == ST_DMA);
    assign own_req    = own_is_dma ? dma_act : cpu_act;
    assign oth_req    = own_is_dma ? cpu_act : dma_act;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_act) begin
                    dma_gnt = 1'b1;
                    state_d = ST_DMA;
                    cnt_d   = CNT_W'(1);
                end else if (cpu_act) begin
                    cpu_gnt = 1'b1;
                    state_d = ST_CPU;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DMA, ST_CPU: begin
                if (own_req && (!oth_req || cnt_q < MAX_CNT)) begin
                    dma_gnt = own_is_dma;
                    cpu_gnt = !own_is_dma;
                    // Only cycles where the other side waits count toward its bound.
                    cnt_d   = oth_req ? cnt_q + 1'b1 : '0;
                end else if (oth_req) begin
                    dma_gnt = !own_is_dma;
                    cpu_gnt = own_is_dma;
                    state_d = own_is_dma ? ST_CPU : ST_DMA;
                    cnt_d   = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_dma_q    <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= mem_en & ~mem_we;
            rd_dma_q  <= dma_gnt;
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

    // The owner tag steers the returning word; the idle side keeps its last word.
    assign cpu_rvalid    = rd_pend_q & ~rd_dma_q;
    assign dma_rvalid    = rd_pend_q & rd_dma_q;
    assign cpu_rdata     = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata     = dma_rvalid ? mem_rdata : dma_rdata_q;
    assign dbg_state     = state_q;
    assign dbg_burst_cnt = cnt_q;
endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Randomized and directed bench for dma_mem_arbiter: a transaction-level arbitration model
// predicts grants and memory traffic; a separate monitor checks read returns from a queue.
module tb_dma_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXB = 16;
    localparam int W = 65;  // {due_cycle[31:0], dma_tag, data[31:0]}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;
    logic [4:0]    dbg_burst_cnt;

    dma_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt)
    );

    // ---------------- clock / cycle counter / memory ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] env_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            else mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : '0;
        end
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    logic [DW-1:0] last_cpu = '0, last_dma = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (owner 0 none, 1 cpu, 2 dma) ----------------
    int m_owner = 0;
    int m_streak = 0;
    int p_cpu = 0, p_dma = 0, cpu_left = 0, dma_left = 0;
    int dma_until_cpu = 0, after_cpu = 0;
    bit cpu_seen = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic new_cpu();
        cpu_req = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = AW'({$urandom_range(0, 15), 2'b00});
        cpu_wdata = $urandom;
    endtask

    task automatic new_dma();
        dma_req = 1'b1;
        dma_we = 1'($urandom_range(0, 1));
        dma_addr = AW'({$urandom_range(0, 15), 2'b00});
        dma_wdata = $urandom;
    endtask

    // One clock cycle: predict and check at negedge, then advance requesters after posedge.
    task automatic step();
        int g, oth;
        bit own_r, oth_r, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        g = 0;
        if (m_owner == 0) begin
            g = dma_req ? 2 : (cpu_req ? 1 : 0);
            oth_r = 0;
        end else begin
            oth = 3 - m_owner;
            own_r = (m_owner == 2) ? dma_req : cpu_req;
            oth_r = (m_owner == 2) ? cpu_req : dma_req;
            if (own_r && (!oth_r || m_streak < MAXB)) g = m_owner;
            else if (oth_r) g = oth;
        end
        we = (g == 2) ? dma_we : cpu_we;
        a = (g == 2) ? dma_addr : cpu_addr;
        d = (g == 2) ? dma_wdata : cpu_wdata;
        check("grant", {cpu_gnt, dma_gnt}, {g == 1, g == 2});
        check("burst_cnt", dbg_burst_cnt, m_streak);
        if (g == 0) check("mem_bus_idle", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
        else check("mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, we, a, d});
        if (g != 0) begin
            if (we) ref_mem[a] = d;
            else exp_q.push_back({32'(cyc + 1), g == 2, ref_rd(a)});
        end
        // stream statistics from what the DUT actually granted
        if (dma_gnt && !cpu_seen) dma_until_cpu++;
        if (cpu_seen && after_cpu == 0 && (cpu_gnt || dma_gnt)) after_cpu = dma_gnt ? 2 : 1;
        if (cpu_gnt) cpu_seen = 1;
        // model state update
        if (g == 0) begin
            m_owner = 0; m_streak = 0;
        end else if (g != m_owner) begin
            m_owner = g; m_streak = 1;
        end else begin
            m_streak = oth_r ? ((m_streak < MAXB) ? m_streak + 1 : m_streak) : 0;
        end
        @(posedge clk);
        #1;
        if (g == 1) cpu_req = 1'b0;
        if (g == 2) dma_req = 1'b0;
        if (!cpu_req && cpu_left > 0 && $urandom_range(0, 99) < p_cpu) begin
            new_cpu(); cpu_left--;
        end
        if (!dma_req && dma_left > 0 && $urandom_range(0, 99) < p_dma) begin
            new_dma(); dma_left--;
        end
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while ((cpu_req || dma_req || cpu_left > 0 || dma_left > 0) && n < bound) begin
            step(); n++;
        end
        if (n >= bound)
            check("phase_timeout", {cpu_req, dma_req, cpu_left != 0, dma_left != 0}, '0);
    endtask

    task automatic reset_dut(input bit hold_reqs);
        rst_n = 1'b0;
        exp_q.delete();
        last_cpu = '0; last_dma = '0;
        m_owner = 0; m_streak = 0;
        cpu_left = 0; dma_left = 0;
        if (hold_reqs) begin new_cpu(); new_dma(); end
        else begin cpu_req = 1'b0; dma_req = 1'b0; end
        repeat (3) begin
            @(negedge clk);
            check("in_reset_outputs", {cpu_gnt, dma_gnt, mem_en, mem_we, cpu_rvalid, dma_rvalid}, '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [W-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_rvalid || dma_rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", {cpu_rvalid, dma_rvalid}, 2'b00);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rvalid_owner", {cpu_rvalid, dma_rvalid}, mon_e[32] ? 2'b01 : 2'b10);
                    check("rvalid_cycle", 32'(cyc), mon_e[64:33]);
                    check("rdata", mon_e[32] ? dma_rdata : cpu_rdata, mon_e[31:0]);
                    if (mon_e[32]) last_dma = mon_e[31:0];
                    else last_cpu = mon_e[31:0];
                end
            end else if (exp_q.size() > 0 && exp_q[0][64:33] < 32'(cyc)) begin
                mon_e = exp_q.pop_front();
                check("missing_rvalid", {cpu_rvalid, dma_rvalid}, mon_e[32] ? 2'b01 : 2'b10);
            end
            if (!cpu_rvalid) check("cpu_rdata_hold", cpu_rdata, last_cpu);
            if (!dma_rvalid) check("dma_rdata_hold", dma_rdata, last_dma);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset with both requesting; DMA must win the first cycle after release.
        reset_dut(1'b1);
        step();
        run_until_idle(50);
        step();

        // DMA streams 40 writes while the CPU waits: 16 DMA grants, one CPU grant, DMA resumes.
        dma_until_cpu = 0; cpu_seen = 0; after_cpu = 0;
        new_cpu();
        new_dma(); dma_we = 1'b1;
        p_dma = 100; dma_left = 39; p_cpu = 0;
        run_until_idle(200);
        check("stream_dma_before_cpu", dma_until_cpu, MAXB);
        check("stream_dma_resumes", after_cpu, 2);
        step();

        // Back-to-back reads from alternating owners.
        env_mem[32'h5000] = 32'hDEADBEEF; ref_mem[32'h5000] = 32'hDEADBEEF;
        env_mem[32'h100] = 32'h12345678; ref_mem[32'h100] = 32'h12345678;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h5000;
        step();
        check("alt_dma_rdata", {dma_rvalid, dma_rdata}, {1'b1, 32'hDEADBEEF});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        step();
        check("alt_cpu_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h12345678});
        check("alt_dma_hold", {dma_rvalid, dma_rdata}, {1'b0, 32'hDEADBEEF});
        repeat (2) step();

        // CPU read granted, then reset: the read must never return.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        step();
        reset_dut(1'b0);
        repeat (2) step();

        // Owner drops its request while the other waits: immediate handover, count 1.
        cpu_seen = 0;
        new_dma(); p_dma = 100; dma_left = 3;
        step();
        new_cpu();
        for (int n = 0; n < 50 && !cpu_seen; n++) step();
        check("handover_cpu_granted", cpu_seen, 1'b1);
        check("handover_burst_cnt", dbg_burst_cnt, 5'd1);
        run_until_idle(50);

        // Random traffic, light then heavy.
        p_cpu = 50; p_dma = 60; cpu_left = 300; dma_left = 300;
        run_until_idle(3000);
        p_cpu = 80; p_dma = 100; cpu_left = 200; dma_left = 200;
        run_until_idle(3000);

        repeat (3) step();
        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
